// File: rtl/oned_hysteresis_trigger.sv
// Hysteresis trigger: turns a filtered sample stream into a debounced "target present" level
// with rise/fall pulses, per-episode peak capture and a saturating rise counter.
module oned_hysteresis_trigger #(
    parameter int DWELL_ON  = 4,
    parameter int DWELL_OFF = 4,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         sample_in,
    input  logic               sample_valid,
    input  logic [7:0]         thresh_hi,
    input  logic [7:0]         thresh_lo,
    output logic               active,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic [7:0]         peak_out,
    output logic [COUNT_W-1:0] event_count
);

    typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;

    localparam logic [7:0] ON_LAST  = 8'(DWELL_ON);
    localparam logic [7:0] OFF_LAST = 8'(DWELL_OFF);

    state_t     state, state_nxt;
    logic [7:0] dwell_cnt, dwell_nxt, cnt_inc;
    logic [7:0] peak, peak_nxt, peak_max;
    logic       hi_hit, lo_hit, rise_nxt, fall_nxt;

    assign hi_hit   = sample_in >= thresh_hi;
    assign lo_hit   = sample_in <= thresh_lo;
    assign cnt_inc  = 8'(dwell_cnt + 8'd1);
    assign peak_max = (sample_in > peak) ? sample_in : peak;

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        peak_nxt  = peak;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sample_valid) begin
            case (state)
                IDLE: begin
                    if (hi_hit) begin
                        peak_nxt = sample_in;
                        if (DWELL_ON == 1) begin
                            state_nxt = ACTIVE;
                            dwell_nxt = 8'd0;
                            rise_nxt  = 1'b1;
                        end else begin
                            state_nxt = ARMING;
                            dwell_nxt = 8'd1;
                        end
                    end
                end
                ARMING: begin
                    peak_nxt = peak_max;
                    if (!hi_hit) begin
                        state_nxt = IDLE;
                        dwell_nxt = 8'd0;
                    end else if (cnt_inc == ON_LAST) begin
                        state_nxt = ACTIVE;
                        dwell_nxt = 8'd0;
                        rise_nxt  = 1'b1;
                    end else begin
                        dwell_nxt = cnt_inc;
                    end
                end
                ACTIVE: begin
                    peak_nxt = peak_max;
                    if (lo_hit) begin
                        if (DWELL_OFF == 1) begin
                            state_nxt = IDLE;
                            dwell_nxt = 8'd0;
                            fall_nxt  = 1'b1;
                        end else begin
                            state_nxt = RELEASING;
                            dwell_nxt = 8'd1;
                        end
                    end
                end
                RELEASING: begin
                    peak_nxt = peak_max;
                    if (!lo_hit) begin
                        state_nxt = ACTIVE;
                        dwell_nxt = 8'd0;
                    end else if (cnt_inc == OFF_LAST) begin
                        state_nxt = IDLE;
                        dwell_nxt = 8'd0;
                        fall_nxt  = 1'b1;
                    end else begin
                        dwell_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    dwell_nxt = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dwell_cnt   <= 8'd0;
            peak        <= 8'd0;
            active      <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            peak_out    <= 8'd0;
            event_count <= '0;
        end else begin
            state      <= state_nxt;
            dwell_cnt  <= dwell_nxt;
            peak       <= peak_nxt;
            active     <= (state_nxt == ACTIVE) || (state_nxt == RELEASING);
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            // The closing sample itself may be the episode maximum.
            if (fall_nxt)
                peak_out <= peak_max;
            if (rise_nxt && (event_count != '1))
                event_count <= event_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_oned_hysteresis_trigger.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a monitor pops and
// compares one entry per clock after the edge that consumed the vector.
module tb_oned_hysteresis_trigger;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample_in = 8'd0;
    logic       sample_valid = 1'b0;
    logic [7:0] thresh_hi = 8'd100;
    logic [7:0] thresh_lo = 8'd60;

    logic        act_a, rise_a, fall_a;
    logic [7:0]  peak_a;
    logic [15:0] cnt_a;
    logic        act_b, rise_b, fall_b;
    logic [7:0]  peak_b;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    oned_hysteresis_trigger #(.DWELL_ON(4), .DWELL_OFF(3), .COUNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .active(act_a), .rise_pulse(rise_a),
        .fall_pulse(fall_a), .peak_out(peak_a), .event_count(cnt_a)
    );

    oned_hysteresis_trigger #(.DWELL_ON(1), .DWELL_OFF(1), .COUNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .active(act_b), .rise_pulse(rise_b),
        .fall_pulse(fall_b), .peak_out(peak_b), .event_count(cnt_b)
    );

    typedef struct {
        string       name;
        logic        sel;
        logic [26:0] val;   // {active, rise, fall, peak[7:0], count[15:0]}
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic A = 1'b0;
    localparam logic B = 1'b1;

    task automatic step(input string nm, input logic sl, input logic r, input logic v,
                        input logic [7:0] s, input logic ea, input logic er, input logic ef,
                        input logic [7:0] ep, input int ec);
        exp_t e;
        @(negedge clk);
        reset        = r;
        sample_valid = v;
        sample_in    = s;
        e.name = nm;
        e.sel  = sl;
        e.val  = {ea, er, ef, ep, 16'(ec)};
        q.push_back(e);
    endtask

    always @(posedge clk) begin : monitor
        exp_t        e;
        logic [26:0] got;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) got = {act_b, rise_b, fall_b, peak_b, 12'd0, cnt_b};
            else       got = {act_a, rise_a, fall_a, peak_a, cnt_a};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got act=%b rise=%b fall=%b peak=%0d cnt=%0d, want act=%b rise=%b fall=%b peak=%0d cnt=%0d",
                         e.name, got[26], got[25], got[24], got[23:16], got[15:0],
                         e.val[26], e.val[25], e.val[24], e.val[23:16], e.val[15:0]);
            end
        end
    end

    initial begin
        // Reset held with a qualifying sample, then release: three more samples complete the dwell
        repeat (3) step("s1_reset", A, 1, 1, 200, 0, 0, 0, 0, 0);
        repeat (3) step("s1_arming", A, 0, 1, 200, 0, 0, 0, 0, 0);
        step("s1_rise", A, 0, 1, 200, 1, 1, 0, 0, 1);
        step("s1_hold", A, 0, 1, 200, 1, 0, 0, 0, 1);

        step("s2_reset", A, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step("s2_dwell", A, 0, 1, 120, 0, 0, 0, 0, 0);
        step("s2_rise", A, 0, 1, 120, 1, 1, 0, 0, 1);
        step("s2_pulse_end", A, 0, 1, 120, 1, 0, 0, 0, 1);

        // Between-threshold sample aborts arming; dwell restarts from scratch
        step("s3_reset", A, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step("s3_dwell", A, 0, 1, 120, 0, 0, 0, 0, 0);
        step("s3_abort", A, 0, 1, 90, 0, 0, 0, 0, 0);
        repeat (3) step("s3_restart", A, 0, 1, 120, 0, 0, 0, 0, 0);
        step("s3_rise", A, 0, 1, 120, 1, 1, 0, 0, 1);

        // Release glitch: the 70 restarts the off-dwell
        step("s4_peak", A, 0, 1, 150, 1, 0, 0, 0, 1);
        repeat (10) step("s4_mid", A, 0, 1, 80, 1, 0, 0, 0, 1);
        repeat (2) step("s4_rel", A, 0, 1, 50, 1, 0, 0, 0, 1);
        step("s4_glitch", A, 0, 1, 70, 1, 0, 0, 0, 1);
        repeat (2) step("s4_rel2", A, 0, 1, 50, 1, 0, 0, 0, 1);
        step("s4_fall", A, 0, 1, 50, 0, 0, 1, 150, 1);
        step("s4_idle", A, 0, 1, 50, 0, 0, 0, 150, 1);

        // Valid gaps carrying 0 must not disturb dwell; 100 and 60 hit on equality
        step("s5_v1", A, 0, 1, 120, 0, 0, 0, 150, 1);
        step("s5_gap", A, 0, 0, 0, 0, 0, 0, 150, 1);
        step("s5_v2_eq", A, 0, 1, 100, 0, 0, 0, 150, 1);
        step("s5_gap", A, 0, 0, 0, 0, 0, 0, 150, 1);
        step("s5_v3", A, 0, 1, 120, 0, 0, 0, 150, 1);
        repeat (2) step("s5_gap", A, 0, 0, 0, 0, 0, 0, 150, 1);
        step("s5_rise", A, 0, 1, 120, 1, 1, 0, 150, 2);
        repeat (3) step("s5_gap_act", A, 0, 0, 0, 1, 0, 0, 150, 2);
        step("s5_rel1", A, 0, 1, 40, 1, 0, 0, 150, 2);
        step("s5_rel2_eq", A, 0, 1, 60, 1, 0, 0, 150, 2);
        step("s5_fall", A, 0, 1, 40, 0, 0, 1, 120, 2);

        // Single-sample dwell and 4-bit counter saturation
        step("s6_reset", B, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            step("s6_rise", B, 0, 1, 120, 1, 1, 0, (i == 1) ? 8'd0 : 8'd120, (i > 15) ? 15 : i);
            step("s6_fall", B, 0, 1, 40, 0, 0, 1, 120, (i > 15) ? 15 : i);
        end
        step("s6_active", B, 0, 1, 120, 1, 1, 0, 120, 15);
        step("s6_mid_reset", B, 1, 1, 40, 0, 0, 0, 0, 0);
        step("s6_after_reset", B, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
